ula_seq: RTL and testbench
==========================

Name: ula_seq

Overview:
Instruction sequencer that drives the 4-bit ALU (`ula_3bits`) as its initiator. It accepts 10-bit instructions over a valid/ready handshake and reads operands from a 4x4-bit register file. It issues `a`/`b`/`op` to the ALU, waits out the ALU's registered latency, then captures `out_ula` and `sinal`. It writes the low nibble back to the destination register and reports the full 9-bit result upstream.

Parameters:
ALU_LATENCY, 1, clock edges from an op being stable on ula_op to a valid ula_result (1 = registered ALU; legal range 1..4)
NREGS, 4, register file depth (fixed at 4; 2-bit register indices)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  instruction valid
in_ready  output  1  sequencer can accept an instruction
in_instr  input  10  {op[9:6], rd[5:4], ra[3:2], rb[1:0]}; for LDI, imm = in_instr[3:0]
ula_a  output  4  operand A to ALU
ula_b  output  4  operand B to ALU
ula_op  output  4  opcode to ALU; 0 when not issuing
ula_result  input  9  ALU out_ula
ula_sinal  input  1  ALU sign output
res_valid  output  1  one-cycle pulse: result written
res_data  output  9  full ALU result, or zero-extended immediate for LDI
res_neg  output  1  captured ula_sinal
res_ovf  output  1  result[8:4] != 0
err  output  1  one-cycle pulse: instruction rejected
rd_sel  input  2  debug register-file read select
rd_data  output  4  combinational read of reg[rd_sel]

Behaviour:
- Reset (async, any state):
  - FSM -> IDLE; all registers -> 0.
  - ula_a, ula_b, ula_op = 0; res_* = 0; err = 0; in_ready = 1.
  - Any in-flight op is dropped with no write and no res_valid.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - in_ready = 1; accept on in_valid & in_ready at a rising edge.
  - Op 0001..0111 (ALU op): latch ula_a = reg[ra], ula_b = reg[rb], ula_op = op, rd; go to ISSUE.
  - Op 0000 (NOP): accepted; no issue, write, res_valid or err; stay in IDLE.
  - Op 1000 (LDI): reg[rd] <= imm at the accept edge. Next cycle: res_valid = 1, res_data = {5'b0, imm}, res_neg = 0, res_ovf = 0. Stay in IDLE, so back-to-back accepts are allowed.
  - Op 1001..1111: accepted; err pulses the next cycle; no other effect.
- ISSUE:
  - in_ready = 0; ula_a, ula_b, ula_op held stable.
  - A wait counter is loaded with ALU_LATENCY-1.
  - Go to CAPTURE if ALU_LATENCY = 1, else go to WAIT.
- WAIT: ALU outputs held; counter decrements each cycle; go to CAPTURE when it reaches 0.
- CAPTURE:
  - Outputs still held.
  - At the exiting edge: reg[rd] <= ula_result[3:0]; res_data <= ula_result; res_neg <= ula_sinal; res_ovf <= |ula_result[8:4]; res_valid pulses for the following cycle.
  - ula_op, ula_a, ula_b -> 0; go to IDLE.
- Latency for an ALU op with ALU_LATENCY = 1:
  - Accept edge T0; ISSUE in cycle 1; CAPTURE in cycle 2.
  - res_valid and the updated register are visible in cycle 3 (3 cycles after accept).
  - Issue-to-issue throughput: one ALU op per 3 cycles.
- Register file:
  - Write and read of the same register on the same edge: a read in IDLE sees the pre-write value.
  - Results are never forwarded, because a new instruction is accepted only after the write completes.
  - rd == ra or rd == rb is legal; operands are latched at accept.
- res_valid and err are single-cycle pulses and are never asserted together.
- res_data, res_neg and res_ovf hold their values until the next res_valid.
- in_valid while in_ready = 0 is ignored; the upstream holds the instruction.

Optional Feature:
ULA_SEQ_DIV0_EN
- Defined: op 0111 (DIV) with reg[rb] == 0 is accepted but not issued. err pulses the cycle after accept; ula_op stays 0; no write; no res_valid; stay in IDLE.
- Undefined: DIV by zero is issued to the ALU like any other op, and whatever the ALU returns is written back.

Test Plan:
1. Reset, then LDI r0=5, LDI r1=3 back-to-back -> res_data 5 then 3 on consecutive cycles; rd_data(r0)=5, rd_data(r1)=3.
2. ADD r2=r0+r1 (op 0001) -> ula_op=1, ula_a=5, ula_b=3 held for ISSUE/CAPTURE; res_valid exactly 3 cycles after accept; res_data=8; r2=8; in_ready=0 during ISSUE/CAPTURE.
3. LDI r0=15, LDI r1=15, MUL r3=r0*r1 (op 0011) -> res_data=225, r3=1, res_ovf=1.
4. Op 1010 and op 0000 -> err pulses once for 1010, nothing for 0000; registers unchanged.
5. Assert rst during CAPTURE of an ADD -> no res_valid; all regs 0; ula_op=0 immediately (async); in_ready=1.
6. With ULA_SEQ_DIV0_EN defined: r1=0, DIV r2=r0/r1 -> err pulse, ula_op never 7, r2 unchanged. Without the macro: ula_op=7 is issued and res_valid pulses.

Source files
------------

// File: rtl/ula_seq.sv
// ula_seq -- instruction sequencer that drives the 4-bit ALU (ula_3bits).
//
// Accepts 10-bit instructions {op[9:6], rd[5:4], ra[3:2], rb[1:0]} over a
// valid/ready handshake and reads operands from a 4x4-bit register file.
// ALU ops (0001..0111) are issued on ula_a/ula_b/ula_op and held through
// the ALU latency. The 9-bit result is then captured, its low nibble is
// written to rd, and the result is reported on res_*. LDI (1000) writes
// imm = instr[3:0] directly. NOP (0000) is a no-op. Ops 1001..1111 pulse err.
//
// Optional feature (compile-time macro ULA_SEQ_DIV0_EN):
//   When defined, DIV (0111) with reg[rb] == 0 is rejected with an err pulse
//   and is never issued to the ALU. When undefined, it is issued normally.
//
// Parameters:
//   ALU_LATENCY  clock edges from a stable ula_op to a valid ula_result (1..4)
//   NREGS        register file depth (fixed at 4, 2-bit indices)
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   in_valid/ready   instruction handshake; in_instr is the instruction word
//   ula_a/b/op       operands and opcode to the ALU (op = 0 when not issuing)
//   ula_result/sinal ALU result and sign inputs
//   res_valid        one-cycle pulse when a result is written
//   res_data/neg/ovf last result, captured sign, and overflow (result[8:4] != 0)
//   err              one-cycle pulse when an instruction is rejected
//   rd_sel/rd_data   debug combinational read of the register file
module ula_seq #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned NREGS       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_instr,
    output logic [3:0] ula_a,
    output logic [3:0] ula_b,
    output logic [3:0] ula_op,
    input  logic [8:0] ula_result,
    input  logic       ula_sinal,
    output logic       res_valid,
    output logic [8:0] res_data,
    output logic       res_neg,
    output logic       res_ovf,
    output logic       err,
    input  logic [1:0] rd_sel,
    output logic [3:0] rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_DIV = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;

    // WAIT lasts ALU_LATENCY-1 cycles, so ISSUE + WAIT span exactly
    // ALU_LATENCY edges before CAPTURE samples the ALU.
    localparam logic [1:0] CNT_INIT = 2'(ALU_LATENCY - 1);

    state_t     state_q, state_d;
    logic [3:0] regs_q [NREGS];
    logic [3:0] regs_d [NREGS];
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] op_q, op_d;
    logic [1:0] rd_q, rd_d;
    logic [1:0] cnt_q, cnt_d;
    logic       res_valid_q, res_valid_d;
    logic [8:0] res_data_q, res_data_d;
    logic       res_neg_q, res_neg_d;
    logic       res_ovf_q, res_ovf_d;
    logic       err_q, err_d;

    // Instruction field decode
    logic [3:0] op_in;
    logic [1:0] rd_in;
    logic [1:0] ra_in;
    logic [1:0] rb_in;
    logic [3:0] imm_in;
    logic       accept;
    logic       div0;

    assign op_in  = in_instr[9:6];
    assign rd_in  = in_instr[5:4];
    assign ra_in  = in_instr[3:2];
    assign rb_in  = in_instr[1:0];
    assign imm_in = in_instr[3:0];

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;

`ifdef ULA_SEQ_DIV0_EN
    assign div0 = (op_in == OP_DIV) && (regs_q[rb_in] == '0);
`else
    assign div0 = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_neg_d   = res_neg_q;
        res_ovf_d   = res_ovf_q;
        err_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op_in == OP_NOP) begin
                        state_d = S_IDLE;
                    end else if (op_in == OP_LDI) begin
                        // Written at the accept edge; staying in IDLE allows
                        // back-to-back LDIs.
                        regs_d[rd_in] = imm_in;
                        res_valid_d   = 1'b1;
                        res_data_d    = {5'b0, imm_in};
                        res_neg_d     = 1'b0;
                        res_ovf_d     = 1'b0;
                    end else if (op_in > OP_LDI) begin
                        err_d = 1'b1;
                    end else if (div0) begin
                        err_d = 1'b1;
                    end else begin
                        // Operands are latched here, so rd == ra/rb is safe.
                        a_d     = regs_q[ra_in];
                        b_d     = regs_q[rb_in];
                        op_d    = op_in;
                        rd_d    = rd_in;
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = (ALU_LATENCY == 1) ? S_CAPTURE : S_WAIT;
            end

            S_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    state_d = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                regs_d[rd_q] = ula_result[3:0];
                res_valid_d  = 1'b1;
                res_data_d   = ula_result;
                res_neg_d    = ula_sinal;
                res_ovf_d    = |ula_result[8:4];
                a_d          = '0;
                b_d          = '0;
                op_d         = '0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            regs_q      <= '{default: '0};
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_neg_q   <= 1'b0;
            res_ovf_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_neg_q   <= res_neg_d;
            res_ovf_q   <= res_ovf_d;
            err_q       <= err_d;
        end
    end

    assign ula_a     = a_q;
    assign ula_b     = b_q;
    assign ula_op    = op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_neg   = res_neg_q;
    assign res_ovf   = res_ovf_q;
    assign err       = err_q;
    assign rd_data   = regs_q[rd_sel];

endmodule

// File: tb/tb_ula_seq.sv
// Testbench for ula_seq: table-driven vectors plus hand sequences, with a
// scoreboard queue of expected res_valid/err events checked by a monitor.
module tb_ula_seq;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_RES  = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    typedef struct {
        logic [1:0] kind;
        logic [8:0] data;
        logic       neg;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [9:0] instr;
        logic [1:0] kind;
        logic [8:0] data;
        logic       neg;
        logic       ovf;
        logic [1:0] chk_reg;
        logic [3:0] chk_val;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_instr;
    logic [3:0] ula_a;
    logic [3:0] ula_b;
    logic [3:0] ula_op;
    logic [8:0] ula_result;
    logic       ula_sinal;
    logic       res_valid;
    logic [8:0] res_data;
    logic       res_neg;
    logic       res_ovf;
    logic       err;
    logic [1:0] rd_sel;
    logic [3:0] rd_data;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [3:0] m_regs [4];
    logic saw_div = 1'b0;

    ula_seq #(.ALU_LATENCY(1), .NREGS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .ula_a      (ula_a),
        .ula_b      (ula_b),
        .ula_op     (ula_op),
        .ula_result (ula_result),
        .ula_sinal  (ula_sinal),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_neg    (res_neg),
        .res_ovf    (res_ovf),
        .err        (err),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment ALU: returns {sinal, result[8:0]}
    function automatic logic [9:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] op);
        logic [8:0] r;
        logic       s;
        s = 1'b0;
        case (op)
            4'd1: r = {5'b0, a} + {5'b0, b};
            4'd2: begin r = {5'b0, a} - {5'b0, b}; s = (a < b); end
            4'd3: r = {5'b0, a} * {5'b0, b};
            4'd4: r = {5'b0, a & b};
            4'd5: r = {5'b0, a | b};
            4'd6: r = {5'b0, a ^ b};
            4'd7: begin
                if (b == 4'd0) begin r = 9'h1F0; s = 1'b1; end
                else r = {5'b0, a / b};
            end
            default: r = 9'd0;
        endcase
        return {s, r};
    endfunction

    // Registered ALU, latency 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {ula_sinal, ula_result} <= '0;
        else     {ula_sinal, ula_result} <= alu_f(ula_a, ula_b, ula_op);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: computes the expected event and updates model registers
    task automatic model(input logic [9:0] instr, output exp_t e);
        logic [3:0] op;
        logic [9:0] r;
        op     = instr[9:6];
        e.kind = K_NONE;
        e.data = '0;
        e.neg  = 1'b0;
        e.ovf  = 1'b0;
        if (op == 4'd8) begin
            m_regs[instr[5:4]] = instr[3:0];
            e.kind = K_RES;
            e.data = {5'b0, instr[3:0]};
        end else if (op >= 4'd9) begin
            e.kind = K_ERR;
        end else if (op != 4'd0) begin
`ifdef ULA_SEQ_DIV0_EN
            if (op == 4'd7 && m_regs[instr[1:0]] == 4'd0) begin
                e.kind = K_ERR;
            end else
`endif
            begin
                r = alu_f(m_regs[instr[3:2]], m_regs[instr[1:0]], op);
                e.kind = K_RES;
                e.data = r[8:0];
                e.neg  = r[9];
                e.ovf  = |r[8:4];
                m_regs[instr[5:4]] = r[3:0];
            end
        end
    endtask

    task automatic send(input logic [9:0] instr, input exp_t e);
        int unsigned n;
        n = 0;
        in_valid = 1'b1;
        in_instr = instr;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("accept_ready", int'(in_ready), 1);
        if (e.kind != K_NONE) sb.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [9:0] instr);
        exp_t e;
        model(instr, e);
        send(instr, e);
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (!(in_ready && sb.size() == 0) && n < 100) begin
            step();
            n++;
        end
        chk("drain_idle", int'(in_ready && sb.size() == 0), 1);
    endtask

    task automatic chk_reg(input string name, input logic [1:0] r, input logic [3:0] v);
        rd_sel = r;
        #1;
        chk(name, int'(rd_data), int'(v));
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ula_op == 4'd7) saw_div = 1'b1;
            if (res_valid || err) begin
                if (res_valid && err) begin
                    chk("valid_err_overlap", 1, 0);
                end else if (sb.size() == 0) begin
                    chk("unexpected_event", int'({res_valid, err}), 0);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", int'({err, res_valid}), int'(e.kind));
                    if (e.kind == K_RES) begin
                        chk("res_data", int'(res_data), int'(e.data));
                        chk("res_neg", int'(res_neg), int'(e.neg));
                        chk("res_ovf", int'(res_ovf), int'(e.ovf));
                    end
                end
            end
        end
    end

    vec_t vecs[13];

    initial begin
        exp_t e;
        logic [9:0] ri;

        vecs[0]  = '{10'b1000_00_0101, K_RES,  9'd5,   1'b0, 1'b0, 2'd0, 4'd5};
        vecs[1]  = '{10'b1000_01_0011, K_RES,  9'd3,   1'b0, 1'b0, 2'd1, 4'd3};
        vecs[2]  = '{10'b0001_10_00_01, K_RES, 9'd8,   1'b0, 1'b0, 2'd2, 4'd8};
        vecs[3]  = '{10'b0010_11_01_00, K_RES, 9'd510, 1'b1, 1'b1, 2'd3, 4'd14};
        vecs[4]  = '{10'b1000_00_1111, K_RES,  9'd15,  1'b0, 1'b0, 2'd0, 4'd15};
        vecs[5]  = '{10'b1000_01_1111, K_RES,  9'd15,  1'b0, 1'b0, 2'd1, 4'd15};
        vecs[6]  = '{10'b0011_11_00_01, K_RES, 9'd225, 1'b0, 1'b1, 2'd3, 4'd1};
        vecs[7]  = '{10'b1010_11_00_00, K_ERR, 9'd0,   1'b0, 1'b0, 2'd3, 4'd1};
        vecs[8]  = '{10'b0000_10_11_11, K_NONE, 9'd0,  1'b0, 1'b0, 2'd2, 4'd8};
        vecs[9]  = '{10'b0110_10_00_11, K_RES, 9'd14,  1'b0, 1'b0, 2'd2, 4'd14};
        vecs[10] = '{10'b0111_10_00_01, K_RES, 9'd1,   1'b0, 1'b0, 2'd2, 4'd1};
        vecs[11] = '{10'b0100_00_00_11, K_RES, 9'd1,   1'b0, 1'b0, 2'd0, 4'd1};
        vecs[12] = '{10'b0101_01_11_10, K_RES, 9'd1,   1'b0, 1'b0, 2'd1, 4'd1};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        rd_sel   = '0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_ula_op", int'(ula_op), 0);
        chk("rst_ula_a", int'(ula_a), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_err", int'(err), 0);
        for (int i = 0; i < 4; i++) chk_reg("rst_reg", 2'(i), 4'd0);

        // Table-driven vectors
        for (int i = 0; i < 13; i++) begin
            model(vecs[i].instr, e);
            e.kind = vecs[i].kind;
            e.data = vecs[i].data;
            e.neg  = vecs[i].neg;
            e.ovf  = vecs[i].ovf;
            send(vecs[i].instr, e);
            wait_idle();
            chk_reg("vec_reg", vecs[i].chk_reg, vecs[i].chk_val);
        end

        // Back-to-back LDI then ADD latency/holding sequence
        send_m(10'b1000_00_0101);
        send_m(10'b1000_01_0011);
        wait_idle();
        rd_sel = 2'd2;
        send_m(10'b0001_10_00_01);
        chk("issue_in_ready", int'(in_ready), 0);
        chk("issue_op", int'(ula_op), 1);
        chk("issue_a", int'(ula_a), 5);
        chk("issue_b", int'(ula_b), 3);
        step();
        chk("cap_in_ready", int'(in_ready), 0);
        chk("cap_op", int'(ula_op), 1);
        chk("cap_a", int'(ula_a), 5);
        chk("cap_b", int'(ula_b), 3);
        chk("cap_res_valid", int'(res_valid), 0);
        step();
        chk("lat3_res_valid", int'(res_valid), 1);
        chk("lat3_reg", int'(rd_data), 8);
        chk("lat3_op_clear", int'(ula_op), 0);
        step();
        chk("pulse_res_valid", int'(res_valid), 0);
        chk("hold_res_data", int'(res_data), 8);
        wait_idle();

        // Reset during CAPTURE drops the op
        in_valid = 1'b1;
        in_instr = 10'b0001_11_00_01;
        step();
        in_valid = 1'b0;
        step();
        chk("pre_rst_op", int'(ula_op), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_op", int'(ula_op), 0);
        chk("async_rst_ready", int'(in_ready), 1);
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_res_valid", int'(res_valid), 0);
        chk("post_rst_res_data", int'(res_data), 0);
        for (int i = 0; i < 4; i++) begin
            m_regs[i] = '0;
            chk_reg("post_rst_reg", 2'(i), 4'd0);
        end

        // Divide by zero
        send_m(10'b1000_00_1001);
        send_m(10'b1000_01_0000);
        send_m(10'b1000_10_0110);
        wait_idle();
        saw_div = 1'b0;
        send_m(10'b0111_10_00_01);
        wait_idle();
`ifdef ULA_SEQ_DIV0_EN
        chk("div0_no_issue", int'(saw_div), 0);
        chk_reg("div0_reg", 2'd2, 4'd6);
`else
        chk("div0_issued", int'(saw_div), 1);
        chk_reg("div0_reg", 2'd2, 4'd0);
`endif

        // Random back-to-back stream against the model
        for (int i = 0; i < 60; i++) begin
            ri = 10'($urandom_range(0, 1023));
            send_m(ri);
        end
        wait_idle();
        for (int i = 0; i < 4; i++) chk_reg("rand_reg", 2'(i), m_regs[i]);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
